// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and the double-width negation helper.
package muldiv_pkg;

    localparam int MAX_W = 64;
    localparam int DBL_W = 2 * MAX_W;

    localparam logic [2:0] FN_MUL    = 3'b000;
    localparam logic [2:0] FN_MULH   = 3'b001;
    localparam logic [2:0] FN_MULHSU = 3'b010;
    localparam logic [2:0] FN_MULHU  = 3'b011;
    localparam logic [2:0] FN_DIV    = 3'b100;
    localparam logic [2:0] FN_DIVU   = 3'b101;
    localparam logic [2:0] FN_REM    = 3'b110;
    localparam logic [2:0] FN_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [DBL_W-1:0] twos_negate(input logic [DBL_W-1:0] v);
        return ~v + {{(DBL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int WORDSIZE = 64
);
    logic                start;
    logic [2:0]          funct3;
    logic [4:0]          rd;
    logic [WORDSIZE-1:0] rs1_data;
    logic [WORDSIZE-1:0] rs2_data;
    logic                flush;
    logic                busy;
    logic                done;
    logic                write_en;
    logic [4:0]          write_addr;
    logic [WORDSIZE-1:0] write_data;

    modport master (
        output start, funct3, rd, rs1_data, rs2_data, flush,
        input  busy, done, write_en, write_addr, write_data
    );

    modport slave (
        input  start, funct3, rd, rs1_data, rs2_data, flush,
        output busy, done, write_en, write_addr, write_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, sign correction in FIXUP, registered writeback in DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int W  = WORDSIZE;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ONES_W   = {W{1'b1}};
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + ONE_W;
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic [4:0]     rd_q, rd_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic           busy_q, busy_d, done_q, done_d, wen_q, wen_d;
    logic [4:0]     waddr_q, waddr_d;
    logic [W-1:0]   wdata_q, wdata_d;

    logic           s1_signed_s, s2_signed_s, s1_neg_s, s2_neg_s, res_neg_s;
    logic           div_zero_s, ovf_s;
    logic [W-1:0]   special_res_s, result_s, quo_fix_s, rem_fix_s;
    logic [W:0]     div_t_s;
    logic [W-1:0]   div_diff_s;
    logic [2*W-1:0] mul_add_s, prod_fix_s;
    logic [DBL_W-1:0] prod_neg_s;

    // Operand decode at issue: signedness, special division cases and their results.
    always_comb begin
        s1_signed_s = 1'b0;
        s2_signed_s = 1'b0;
        case (bus.funct3)
            FN_MUL, FN_MULH, FN_DIV, FN_REM: begin
                s1_signed_s = 1'b1;
                s2_signed_s = 1'b1;
            end
            FN_MULHSU: begin
                s1_signed_s = 1'b1;
                s2_signed_s = 1'b0;
            end
            default: begin
                s1_signed_s = 1'b0;
                s2_signed_s = 1'b0;
            end
        endcase
        s1_neg_s   = s1_signed_s && bus.rs1_data[W-1];
        s2_neg_s   = s2_signed_s && bus.rs2_data[W-1];
        res_neg_s  = (bus.funct3 == FN_REM) ? s1_neg_s : (s1_neg_s ^ s2_neg_s);
        div_zero_s = bus.funct3[2] && (bus.rs2_data == ZERO_W);
        ovf_s      = ((bus.funct3 == FN_DIV) || (bus.funct3 == FN_REM)) &&
                     (bus.rs1_data == MIN_NEG) && (bus.rs2_data == ONES_W);
        if (div_zero_s) begin
            special_res_s = bus.funct3[1] ? bus.rs1_data : ONES_W;
        end else begin
            special_res_s = bus.funct3[1] ? ZERO_W : bus.rs1_data;
        end
    end

    // Iteration step datapath and FIXUP sign correction / result selection.
    always_comb begin
        div_t_s    = {rem_q, a_q[cnt_q]};
        div_diff_s = div_t_s[W-1:0] - b_q;
        mul_add_s  = a_q[cnt_q] ? {ZERO_W, b_q} : {ZERO_W, ZERO_W};
        prod_neg_s = twos_negate(DBL_W'(prod_q));
        prod_fix_s = neg_q ? prod_neg_s[2*W-1:0] : prod_q;
        quo_fix_s  = neg_q ? neg_w(quo_q) : quo_q;
        rem_fix_s  = neg_q ? neg_w(rem_q) : rem_q;
        case (op_q)
            FN_MUL:                       result_s = prod_fix_s[W-1:0];
            FN_MULH, FN_MULHSU, FN_MULHU: result_s = prod_fix_s[2*W-1:W];
            FN_DIV, FN_DIVU:              result_s = quo_fix_s;
            default:                      result_s = rem_fix_s;
        endcase
    end

    // FSM next state and register next values; flush overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        wen_d   = 1'b0;
        busy_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.funct3;
                    rd_d   = bus.rd;
                    neg_d  = res_neg_s;
                    a_d    = s1_neg_s ? neg_w(bus.rs1_data) : bus.rs1_data;
                    b_d    = s2_neg_s ? neg_w(bus.rs2_data) : bus.rs2_data;
                    prod_d = {ZERO_W, ZERO_W};
                    rem_d  = ZERO_W;
                    quo_d  = ZERO_W;
                    if (div_zero_s || ovf_s) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        wen_d   = (bus.rd != 5'd0);
                        waddr_d = bus.rd;
                        wdata_d = special_res_s;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_LAST;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    rem_d = (div_t_s >= {1'b0, b_q}) ? div_diff_s : div_t_s[W-1:0];
                    quo_d = {quo_q[W-2:0], (div_t_s >= {1'b0, b_q})};
                end else begin
                    prod_d = {prod_q[2*W-2:0], 1'b0} + mul_add_s;
                end
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_CALC;
                    cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_FIXUP: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                wen_d   = (rd_q != 5'd0);
                waddr_d = rd_q;
                wdata_d = result_s;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            wen_d   = 1'b0;
            waddr_d = waddr_q;
            wdata_d = wdata_q;
            busy_d  = 1'b0;
        end else begin
            busy_d  = (state_d != S_IDLE);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= 3'b000;
            rd_q    <= 5'd0;
            neg_q   <= 1'b0;
            a_q     <= ZERO_W;
            b_q     <= ZERO_W;
            prod_q  <= {ZERO_W, ZERO_W};
            rem_q   <= ZERO_W;
            quo_q   <= ZERO_W;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= ZERO_W;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.write_en   = wen_q;
    assign bus.write_addr = waddr_q;
    assign bus.write_data = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, control corner
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 64;
    localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
    localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_if #(.WORDSIZE(W)) bus ();
    muldiv_unit #(.WORDSIZE(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [4:0]  rd;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain RISC-V M-extension arithmetic on wide integers.
    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb, sq;
        sa = a;
        sb = b;
        case (f)
            T_MUL:    begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
            T_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            T_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            T_MULHU:  begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            T_DIV: begin
                if (b == 64'd0) return ONES;
                if (a == MINN && b == ONES) return a;
                sq = sa / sb;
                return sq;
            end
            T_DIVU:   return (b == 64'd0) ? ONES : a / b;
            T_REM: begin
                if (b == 64'd0) return a;
                if (a == MINN && b == ONES) return 64'd0;
                sq = sa % sb;
                return sq;
            end
            default:  return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [63:0] a,
                                       input logic [63:0] b);
        if (f[2] && (b == 64'd0)) return 1;
        if ((f == T_DIV || f == T_REM) && a == MINN && b == ONES) return 1;
        return W + 2;
    endfunction

    // Issue one op and wait (bounded) for done; lat counts cycles after acceptance.
    task automatic do_op(input logic [2:0] f, input logic [4:0] r, input logic [63:0] a,
                         input logic [63:0] b, output int lat, output logic [63:0] wd,
                         output logic we, output logic [4:0] wa, output logic busy1);
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.rd = r; bus.rs1_data = a; bus.rs2_data = b;
        lat = 0; k = 0; wd = 64'd0; we = 1'b0; wa = 5'd0; busy1 = 1'b0;
        while (lat == 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.start = 1'b0;
                busy1 = bus.busy;
            end
            if (bus.done) begin
                lat = k; wd = bus.write_data; we = bus.write_en; wa = bus.write_addr;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] f, input logic [4:0] r,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] exp, input int exp_lat);
        int lat;
        logic [63:0] wd;
        logic we, busy1;
        logic [4:0] wa;
        do_op(f, r, a, b, lat, wd, we, wa, busy1);
        chk({tag, "_busy"}, 64'(busy1), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, wd, exp);
        chk({tag, "_wen"}, 64'(we), 64'(r != 5'd0));
        chk({tag, "_waddr"}, 64'(wa), 64'(r));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hold"}, bus.write_data, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_wen"}, 64'(bus.write_en), 64'd0);
        chk({tag, "_waddr"}, 64'(bus.write_addr), 64'd0);
        chk({tag, "_wdata"}, bus.write_data, 64'd0);
    endtask

    initial begin
        int seen, dones;
        logic [2:0]  rf;
        logic [4:0]  rr;
        logic [63:0] ra, rb;
        int sel;

        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0; bus.rd = 5'd0;
        bus.rs1_data = 64'd0; bus.rs2_data = 64'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        vecs.push_back('{T_MUL,    5'd5,  64'd7, ONES - 64'd2, 64'hFFFF_FFFF_FFFF_FFEB, 66});
        vecs.push_back('{T_MULHU,  5'd1,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66});
        vecs.push_back('{T_MULH,   5'd2,  ONES, ONES, 64'd0, 66});
        vecs.push_back('{T_MULHSU, 5'd6,  ONES, 64'd2, ONES, 66});
        vecs.push_back('{T_DIV,    5'd3,  ONES - 64'd6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66});
        vecs.push_back('{T_REM,    5'd3,  ONES - 64'd6, 64'd2, ONES, 66});
        vecs.push_back('{T_DIVU,   5'd7,  64'd7, 64'd2, 64'd3, 66});
        vecs.push_back('{T_DIV,    5'd8,  64'd7, ONES - 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 66});
        vecs.push_back('{T_REMU,   5'd9,  64'd100, 64'd7, 64'd2, 66});
        vecs.push_back('{T_DIVU,   5'd4,  64'd5, 64'd0, ONES, 1});
        vecs.push_back('{T_REM,    5'd4,  64'd5, 64'd0, 64'd5, 1});
        vecs.push_back('{T_DIV,    5'd10, MINN, ONES, MINN, 1});
        vecs.push_back('{T_REM,    5'd11, MINN, ONES, 64'd0, 1});
        vecs.push_back('{T_MUL,    5'd0,  64'd3, 64'd4, 64'd12, 66});

        foreach (vecs[i])
            run_and_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].rd, vecs[i].a,
                          vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Flush ten cycles after acceptance aborts with no write.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = T_MULHU; bus.rd = 5'd12;
        bus.rs1_data = 64'd99; bus.rs2_data = 64'd99;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done || bus.write_en) seen++;
        end
        chk("flush_no_done", 64'(seen), 64'd0);
        chk("flush_hold", bus.write_data, 64'd12);
        run_and_check("after_flush", T_DIVU, 5'd13, 64'd1000, 64'd10, 64'd100, 66);

        // start held through the whole operation executes it exactly once.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = T_MUL; bus.rd = 5'd14;
        bus.rs1_data = 64'd6; bus.rs2_data = 64'd9;
        dones = 0; seen = 0;
        while (dones == 0 && seen < 200) begin
            @(negedge clk);
            seen++;
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        chk("hold_lat", 64'(seen), 64'd66);
        chk("hold_data", bus.write_data, 64'd54);
        repeat (80) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("hold_one_op", 64'(dones), 64'd1);

        // Reset mid-operation clears outputs and discards the op.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = T_MUL; bus.rd = 5'd15;
        bus.rs1_data = 64'd5; bus.rs2_data = 64'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        rst = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done || bus.write_en) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            rr = 5'($urandom_range(0, 31));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 64'd0;
            else if (sel == 1) begin ra = MINN; rb = ONES; end
            else if (sel == 2) begin
                ra = 64'($urandom_range(0, 1000));
                rb = 64'($urandom_range(1, 50));
                if ($urandom_range(0, 1) == 1) ra = -ra;
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            run_and_check($sformatf("rnd%0d", n), rf, rr, ra, rb, ref_model(rf, ra, rb),
                          exp_latency(rf, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
